wbmemdev_lat: RTL and testbench
===============================

WBMEMDEV_LAT -- requirements
Module: wbmemdev_lat

Interface
REQ-001 Parameter AW, default 30: bus word-address width.
REQ-002 Parameter MAW, default 15: memory word-address width; depth 2^MAW words of 32 bits.
REQ-003 Parameter BASE, default 1: required value of i_wb_addr[AW-1:MAW]; any other value is out of window.
REQ-004 Parameter LAT, default 1, range 1..8: cycles from accepted strobe to ack/err.
REQ-005 Parameter STALL_PERIOD, default 0: 0 means never stall; N>0 means o_wb_stall high one cycle in every N.
REQ-006 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-007 i_rst_n  input  1  asynchronous, active-low reset.
REQ-008 i_wb_cyc, i_wb_stb, i_wb_we  input  1 each  Wishbone pipelined cycle, strobe, write enable.
REQ-009 i_wb_addr  input  AW  word address.
REQ-010 i_wb_data  input  32  write data.
REQ-011 i_wb_sel  input  4  byte enables, bit n for byte lane n.
REQ-012 o_wb_stall, o_wb_ack, o_wb_err  output  1 each  stall, acknowledge, bus error.
REQ-013 o_wb_data  output  32  read data, valid with o_wb_ack.

Function
REQ-014 Request accepted when i_wb_stb && !o_wb_stall; accepted requests are returned strictly in order.
REQ-015 Exactly LAT cycles after acceptance, exactly one of o_wb_ack / o_wb_err is high for one cycle; back-to-back acceptances give back-to-back responses.
REQ-016 Error causes: i_wb_stb without i_wb_cyc, or address outside window (REQ-003); errored writes do not modify memory; errored reads return o_wb_data 0.
REQ-017 In-window write: bytes with i_wb_sel bit set written at the acceptance edge; other bytes unchanged; sel 4'h0 still acks.
REQ-018 In-window read: o_wb_data holds the word at i_wb_addr[MAW-1:0] as of the acceptance edge (write-then-read to same address in consecutive cycles returns new data).
REQ-019 Response pipeline: LAT-deep shift register of {valid, err, data}; no other state machine.
REQ-020 i_wb_cyc low flushes every in-flight entry on the next edge; no ack/err for flushed requests; writes already committed stay committed.
REQ-021 Stall counter: free-running modulo STALL_PERIOD; o_wb_stall high when count == STALL_PERIOD-1; counting is independent of bus activity.
REQ-022 o_wb_stall is 0 whenever STALL_PERIOD == 0; o_wb_ack and o_wb_err never both high.
REQ-023 o_wb_data is 0 on any cycle o_wb_ack is low.

Reset
REQ-024 i_rst_n low asynchronously clears: pipeline valid bits, o_wb_ack 0, o_wb_err 0, o_wb_data 0, stall counter 0, o_wb_stall 0.
REQ-025 Memory contents are not reset; reset mid-transaction discards all in-flight responses, and writes already accepted stay committed.
REQ-026 First acceptance possible on the first rising edge after i_rst_n deasserts.

Structure
REQ-027 Shared package holds: bus data width 32, sel width 4, default LAT, default AW/MAW.
REQ-028 One sub-module, wbdelay_pipe, parametrised in depth and payload width, implements the REQ-019 response pipeline with asynchronous clear and synchronous flush.
REQ-029 Memory array is inferrable as block RAM: one write port with byte enables, one read port.

Verification
REQ-030 LAT=3, STALL_PERIOD=0: write 32'hDEADBEEF to addr 0x8005 (BASE=1, MAW=15), then read 0x8005 -> ack 3 cycles after each strobe, read data 32'hDEADBEEF.
REQ-031 Write sel 4'b0101 data 32'h11223344 over 32'hAAAAAAAA -> subsequent read returns 32'hAA22AA44.
REQ-032 Read addr 0x10005 (out of window) -> o_wb_err after LAT cycles, no ack, memory at 0x0005 unchanged.
REQ-033 LAT=4: four back-to-back reads, drop i_wb_cyc after the 2nd response -> exactly 2 acks, none after.
REQ-034 STALL_PERIOD=3, continuous strobes for 12 cycles -> o_wb_stall high on cycles 2,5,8,11; 8 acceptances; 8 in-order acks.
REQ-035 Assert i_rst_n low mid-burst (LAT=2, 2 in flight) -> ack/err/stall drop immediately; no responses after release; the written data persists.

Source files
------------

// File: rtl/wbmemdev_lat_pkg.sv
// ---------------------------------------------------------------------------
// wbmemdev_lat_pkg
// Shared constants and types for the latency-configurable Wishbone memory.
//   DW       bus data width (32)
//   SW       byte-select width (4)
//   DEF_*    default parameter values for the top level
//   resp_t   one response-pipeline payload: error flag plus read data
// ---------------------------------------------------------------------------
package wbmemdev_lat_pkg;

    localparam int DW      = 32;
    localparam int SW      = 4;
    localparam int DEF_LAT = 1;
    localparam int DEF_AW  = 30;
    localparam int DEF_MAW = 15;

    // Payload carried alongside the valid bit through the response pipeline.
    // data is always zero for errored entries and for write acknowledges.
    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } resp_t;

    localparam int RESP_W = $bits(resp_t);

endpackage : wbmemdev_lat_pkg

// File: rtl/wbdelay_pipe.sv
// ---------------------------------------------------------------------------
// wbdelay_pipe
// Fixed-depth shift register of {valid, payload} entries. An entry presented
// on valid_i/data_i appears on valid_o/data_o exactly DEPTH edges later.
//   clk_i    clock (rising edge)
//   rst_ni   asynchronous active-low clear of every stage
//   flush_i  synchronous flush: every entry already in the pipe is dropped on
//            this edge; the entry being loaded on the same edge is kept
//   valid_i  load a new entry into stage 0
//   data_i   payload of the new entry
//   valid_o  last-stage valid
//   data_o   last-stage payload (zero whenever valid_o is low)
// ---------------------------------------------------------------------------
module wbdelay_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 33
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [W-1:0]     data_q [DEPTH];
    logic [W-1:0]     data_d [DEPTH];

    // Next-state of every stage: stage 0 takes the new entry, the others shift
    // unless a flush kills what is in flight. Empty stages carry a zero payload
    // so the consumer can use data_o without further gating.
    always_comb begin
        valid_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = '0;
        end
        valid_d[0] = valid_i;
        if (valid_i) begin
            data_d[0] = data_i;
        end else begin
            data_d[0] = '0;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (flush_i) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end else begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule : wbdelay_pipe

// File: rtl/wbmemdev_lat.sv
// ---------------------------------------------------------------------------
// wbmemdev_lat
// Wishbone pipelined slave memory with a fixed response latency and an
// optional periodic stall.
//   i_clk          clock (rising edge)
//   i_rst_n        asynchronous active-low reset (memory contents are kept)
//   i_wb_cyc       bus cycle; low flushes all in-flight responses
//   i_wb_stb       request strobe; accepted when o_wb_stall is low
//   i_wb_we        write enable
//   i_wb_addr      word address; upper AW-MAW bits must equal BASE
//   i_wb_data      write data
//   i_wb_sel       byte enables, bit n for byte lane n
//   o_wb_stall     high one cycle in every STALL_PERIOD (never when 0)
//   o_wb_ack       acknowledge, LAT cycles after acceptance
//   o_wb_err       bus error, LAT cycles after acceptance (no cyc / out of window)
//   o_wb_data      read data, zero whenever o_wb_ack is low
// ---------------------------------------------------------------------------
module wbmemdev_lat
    import wbmemdev_lat_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int MAW          = DEF_MAW,
    parameter int BASE         = 1,
    parameter int LAT          = DEF_LAT,
    parameter int STALL_PERIOD = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [DW-1:0] i_wb_data,
    input  logic [SW-1:0] i_wb_sel,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic          o_wb_err,
    output logic [DW-1:0] o_wb_data
);

    localparam int            MEM_DEPTH = 1 << MAW;
    localparam int            HW        = AW - MAW;
    localparam logic [HW-1:0] BASE_W    = HW'(BASE);

    logic           stall_s;
    logic           in_win_s;
    logic           accept_s;
    logic           err_s;
    logic           wr_en_s;
    logic [MAW-1:0] idx_s;
    resp_t          req_s;
    resp_t          rsp_s;
    logic           rsp_valid_s;

    logic [DW-1:0]  mem_q [MEM_DEPTH];

    assign idx_s = i_wb_addr[MAW-1:0];

    // Request decode. The read word is sampled from the array before this
    // edge's write lands, which is fine because one request is either a read
    // or a write; a write followed by a read on the next edge sees new data.
    always_comb begin
        in_win_s  = (i_wb_addr[AW-1:MAW] == BASE_W);
        accept_s  = i_wb_stb & ~stall_s;
        err_s     = ~i_wb_cyc | ~in_win_s;
        wr_en_s   = accept_s & ~err_s & i_wb_we;
        req_s.err = err_s;
        if (accept_s && !err_s && !i_wb_we) begin
            req_s.data = mem_q[idx_s];
        end else begin
            req_s.data = '0;
        end
    end

    // Byte-enabled write port; no reset so the array maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < SW; b++) begin
                if (i_wb_sel[b]) begin
                    mem_q[idx_s][8*b +: 8] <= i_wb_data[8*b +: 8];
                end
            end
        end
    end

    // Stall generator: free-running counter, independent of bus traffic.
    generate
        if (STALL_PERIOD > 0) begin : g_stall
            localparam int            CW   = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
            localparam logic [CW-1:0] LAST = CW'(STALL_PERIOD - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          stall_q;

            // Wrap the count at STALL_PERIOD-1.
            always_comb begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Stall is registered from the next count so it is high exactly
            // while the count register holds LAST.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    cnt_q   <= '0;
                    stall_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    stall_q <= (cnt_d == LAST);
                end
            end

            assign stall_s = stall_q;
        end else begin : g_nostall
            assign stall_s = 1'b0;
        end
    endgenerate

    // A dropped cycle kills everything in flight; a strobe seen on the same
    // edge still enters the pipe (as an error) and survives only if i_wb_cyc
    // is high again on the following edge.
    wbdelay_pipe #(
        .DEPTH (LAT),
        .W     (RESP_W)
    ) u_pipe (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .flush_i (~i_wb_cyc),
        .valid_i (accept_s),
        .data_i  (req_s),
        .valid_o (rsp_valid_s),
        .data_o  (rsp_s)
    );

    assign o_wb_stall = stall_s;
    assign o_wb_ack   = rsp_valid_s & ~rsp_s.err;
    assign o_wb_err   = rsp_valid_s & rsp_s.err;
    assign o_wb_data  = rsp_s.data;

endmodule : wbmemdev_lat

// File: tb/tb_wbmemdev_lat.sv
// ---------------------------------------------------------------------------
// tb_wbmemdev_lat
// Two instances share one stimulus stream: u0 (LAT=3, no stall) and
// u1 (LAT=4, stall every 3rd cycle). A reference model per instance decides
// acceptance, error and read data from the bus rules and queues the expected
// response with the cycle it is due; a monitor on the falling edge pops and
// compares every cycle.
// ---------------------------------------------------------------------------
module tb_wbmemdev_lat;

    localparam int NI = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        cyc, stb, we;
    logic [29:0] addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [1:0]  stall_w, ack_w, err_w;
    logic [31:0] dat_w [NI];

    always #5 i_clk = ~i_clk;

    wbmemdev_lat #(.AW(30), .MAW(15), .BASE(1), .LAT(3), .STALL_PERIOD(0)) u0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel),
        .o_wb_stall(stall_w[0]), .o_wb_ack(ack_w[0]), .o_wb_err(err_w[0]),
        .o_wb_data(dat_w[0])
    );

    wbmemdev_lat #(.AW(30), .MAW(15), .BASE(1), .LAT(4), .STALL_PERIOD(3)) u1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .i_wb_we(we), .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel),
        .o_wb_stall(stall_w[1]), .o_wb_ack(ack_w[1]), .o_wb_err(err_w[1]),
        .o_wb_data(dat_w[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 3 : 4;
    endfunction

    function automatic int sp_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    typedef struct {
        int          inst;
        int          due;
        bit          err;
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mem_v [int];
    logic [3:0]  mem_k [int];
    int          edge_n = 0;
    int          scnt [NI];
    bit          sexp [NI];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;

    task automatic check(input string name, input int inst, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d edge=%0d got=%h expected=%h", name, inst, edge_n, got, exp);
        end
    endtask

    // Reference model for one instance at one rising edge.
    task automatic model_edge(input int i);
        exp_t        e;
        int          key;
        logic [31:0] v;
        logic [3:0]  kn;
        if (!cyc) begin
            for (int k = exp_q.size() - 1; k >= 0; k--) begin
                if (exp_q[k].inst == i && exp_q[k].due >= edge_n) exp_q.delete(k);
            end
        end
        if (stb && !sexp[i]) begin
            e.inst = i;
            e.due  = edge_n + lat_of(i) - 1;
            e.err  = !cyc || (addr[29:15] != 15'd1);
            e.data = 32'h0;
            e.mask = 32'hFFFF_FFFF;
            key    = i * 65536 + int'(addr[14:0]);
            if (!e.err) begin
                if (!mem_k.exists(key)) begin
                    mem_k[key] = 4'h0;
                    mem_v[key] = 32'h0;
                end
                v  = mem_v[key];
                kn = mem_k[key];
                if (we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sel[b]) begin
                            v[8*b +: 8] = wdat[8*b +: 8];
                            kn[b]       = 1'b1;
                        end
                    end
                    mem_v[key] = v;
                    mem_k[key] = kn;
                end else begin
                    e.data = v;
                    for (int b = 0; b < 4; b++) e.mask[8*b +: 8] = {8{kn[b]}};
                end
            end
            exp_q.push_back(e);
        end
        if (sp_of(i) > 0) begin
            scnt[i] = (scnt[i] + 1) % sp_of(i);
            sexp[i] = (scnt[i] == sp_of(i) - 1);
        end
    endtask

    // Monitor for one instance in the current cycle.
    task automatic mon_inst(input int i);
        int          idx;
        logic        ea, ee;
        logic [31:0] ed, em;
        idx = -1;
        ea  = 1'b0;
        ee  = 1'b0;
        ed  = 32'h0;
        em  = 32'hFFFF_FFFF;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (exp_q[k].inst == i) begin
                idx = k;
                break;
            end
        end
        if (i_rst_n && idx >= 0 && exp_q[idx].due <= edge_n) begin
            ea = !exp_q[idx].err;
            ee = exp_q[idx].err;
            ed = exp_q[idx].data;
            em = exp_q[idx].mask;
            exp_q.delete(idx);
        end
        check("ack",   i, 32'(ack_w[i]),   32'(ea));
        check("err",   i, 32'(err_w[i]),   32'(ee));
        check("data",  i, dat_w[i] & em,   ed & em);
        check("stall", i, 32'(stall_w[i]), 32'(sexp[i]));
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            if (i_rst_n) begin
                edge_n++;
                for (int i = 0; i < NI; i++) model_edge(i);
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                for (int i = 0; i < NI; i++) mon_inst(i);
            end
        end
    end

    task automatic drive(input logic c, input logic s, input logic w, input logic [29:0] a,
                         input logic [31:0] d, input logic [3:0] sl);
        cyc  = c;
        stb  = s;
        we   = w;
        addr = a;
        wdat = d;
        sel  = sl;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n, input logic c);
        for (int k = 0; k < n; k++) drive(c, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset(input int n);
        cyc     = 1'b0;
        stb     = 1'b0;
        i_rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NI; i++) begin
            scnt[i] = 0;
            sexp[i] = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
        i_rst_n = 1'b1;
    endtask

    logic [14:0] hi;
    int          left;

    initial begin
        i_rst_n = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 30'h0; wdat = 32'h0; sel = 4'h0;
        @(posedge i_clk);
        #1;
        mon_en = 1'b1;
        do_reset(3);
        idle(2, 1'b1);

        // Write then read one word.
        drive(1'b1, 1'b1, 1'b1, 30'h8005, 32'hDEADBEEF, 4'hF);
        idle(6, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 30'h8005, 32'h0, 4'hF);
        idle(6, 1'b1);

        // Partial byte write over a full word, then read back-to-back.
        drive(1'b1, 1'b1, 1'b1, 30'h8006, 32'hAAAAAAAA, 4'hF);
        drive(1'b1, 1'b1, 1'b1, 30'h8006, 32'h11223344, 4'b0101);
        drive(1'b1, 1'b1, 1'b0, 30'h8006, 32'h0, 4'hF);
        idle(6, 1'b1);

        // Out-of-window read and write, then confirm the in-window word.
        drive(1'b1, 1'b1, 1'b0, 30'h10005, 32'h0, 4'hF);
        drive(1'b1, 1'b1, 1'b1, 30'h10005, 32'h0BADF00D, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 30'h8005, 32'h0, 4'hF);
        idle(6, 1'b1);

        // Strobe without cycle, cycle restored on the next edge.
        drive(1'b0, 1'b1, 1'b0, 30'h8005, 32'h0, 4'hF);
        idle(6, 1'b1);

        // Four back-to-back reads, cycle dropped while responses are in flight.
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b0, (k % 2 == 0) ? 30'h8005 : 30'h8006, 32'h0, 4'hF);
        idle(1, 1'b1);
        idle(4, 1'b0);
        idle(2, 1'b1);

        // Continuous strobes for 12 cycles from a fresh reset.
        do_reset(2);
        for (int k = 0; k < 12; k++) drive(1'b1, 1'b1, 1'b0, (k % 2 == 0) ? 30'h8005 : 30'h8006, 32'h0, 4'hF);
        idle(6, 1'b1);

        // Reset while writes and a read are in flight; writes must persist.
        drive(1'b1, 1'b1, 1'b1, 30'h8010, 32'hCAFEF00D, 4'hF);
        drive(1'b1, 1'b1, 1'b1, 30'h8011, 32'h12345678, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 30'h8010, 32'h0, 4'hF);
        do_reset(2);
        idle(6, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 30'h8010, 32'h0, 4'hF);
        drive(1'b1, 1'b1, 1'b0, 30'h8011, 32'h0, 4'hF);
        idle(6, 1'b1);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            hi = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(0, 2)) : 15'd1;
            drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1), {hi, 15'($urandom_range(0, 15))},
                  $urandom, 4'($urandom));
        end
        idle(8, 1'b1);

        for (int i = 0; i < NI; i++) begin
            left = 0;
            for (int k = 0; k < exp_q.size(); k++) begin
                if (exp_q[k].inst == i) left++;
            end
            check("drain", i, 32'(left), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wbmemdev_lat
